rgb_pwm_fader: RTL and testbench

- Sits directly downstream of the RGB sequencer.
- Consumes its 3-bit on/off colour pattern and drives the three LED pins with PWM.
- Each channel's duty ramps smoothly toward its target (fade in/out) instead of snapping, with a global brightness ceiling.
- Outputs go straight to the board LED pins.

---
 rtl/rgb_pwm_fader.sv | 87 ++++++++
 tb/tb_rgb_pwm_fader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_fader.sv
// Three-channel PWM LED driver: duties fade 1 LSB per prescaler tick toward
// the on/off pattern from the sequencer, scaled by a brightness ceiling.
module rgb_pwm_fader #(
  parameter int PWM_BITS   = 8,
  parameter int FADE_TICKS = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [2:0]          rgb_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [2:0]          pwm_out,
  output logic                settled
);

  localparam int FW = (FADE_TICKS > 1) ? $clog2(FADE_TICKS) : 1;
  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [PWM_BITS-1:0] CNT_LAST  = MAX - 1'b1;
  localparam logic [FW-1:0]       FADE_LAST = FW'(FADE_TICKS - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [FW-1:0]       fade_cnt_q, fade_cnt_d;
  logic [PWM_BITS-1:0] work_q [3];
  logic [PWM_BITS-1:0] work_d [3];
  logic [PWM_BITS-1:0] act_q  [3];
  logic [PWM_BITS-1:0] act_d  [3];
  logic [PWM_BITS-1:0] target [3];
  logic [PWM_BITS-1:0] level;
  logic [2:0]          pwm_out_q, pwm_out_d;
  logic                settled_q, settled_d;
  logic                fade_tick;
  logic                wrap;

  always_comb begin
    level      = (brightness > MAX) ? MAX : brightness;
    fade_tick  = (fade_cnt_q == FADE_LAST);
    wrap       = (pwm_cnt_q == CNT_LAST);
    pwm_cnt_d  = wrap ? '0 : pwm_cnt_q + 1'b1;
    fade_cnt_d = fade_tick ? '0 : fade_cnt_q + 1'b1;
    pwm_out_d  = '0;
    settled_d  = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      target[i]    = rgb_in[i] ? level : '0;
      // active duty snapshots the pre-step working value, so a coincident
      // fade step only shows up in the following period
      act_d[i]     = wrap ? work_q[i] : act_q[i];
      pwm_out_d[i] = ena && (pwm_cnt_q < act_q[i]);
      work_d[i]    = work_q[i];
      if (fade_tick && ena) begin
        if (work_q[i] < target[i]) begin
          work_d[i] = work_q[i] + 1'b1;
        end else if (work_q[i] > target[i]) begin
          work_d[i] = work_q[i] - 1'b1;
        end
      end
      if (work_q[i] != target[i]) begin
        settled_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q  <= '0;
      fade_cnt_q <= '0;
      pwm_out_q  <= '0;
      settled_q  <= 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
        work_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      fade_cnt_q <= fade_cnt_d;
      pwm_out_q  <= pwm_out_d;
      settled_q  <= settled_d;
      for (int unsigned i = 0; i < 3; i++) begin
        work_q[i] <= work_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

  assign pwm_out = pwm_out_q;
  assign settled = settled_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader at PWM_BITS=4, FADE_TICKS=4: an arithmetic model
// checked every cycle plus directed scenarios with hand-computed figures.
module tb_rgb_pwm_fader;

  localparam int MAXV = 15;
  localparam int FT   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [2:0] rgb_in = 3'b111;
  logic [3:0] brightness = 4'hF;
  logic [2:0] pwm_out;
  logic       settled;

  int n_checks = 0;
  int n_errs   = 0;

  rgb_pwm_fader #(.PWM_BITS(4), .FADE_TICKS(FT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .rgb_in     (rgb_in),
    .brightness (brightness),
    .pwm_out    (pwm_out),
    .settled    (settled)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: edges since reset give the PWM phase and fade tick directly.
  int         m_cyc = 0;
  int         m_work [3];
  int         m_act  [3];
  int         m_tgt  [3];
  logic [2:0] m_out = 3'b000;
  logic       m_set = 1'b1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cyc = 0;
      m_out = 3'b000;
      m_set = 1'b1;
      for (int i = 0; i < 3; i++) begin
        m_work[i] = 0;
        m_act[i]  = 0;
      end
    end else begin
      int  phase;
      bit  all_eq;
      phase  = m_cyc % MAXV;
      all_eq = 1'b1;
      for (int i = 0; i < 3; i++) begin
        m_tgt[i] = rgb_in[i] ? ((int'(brightness) > MAXV) ? MAXV : int'(brightness)) : 0;
        m_out[i] = ena && (phase < m_act[i]);
        if (m_work[i] != m_tgt[i]) all_eq = 1'b0;
      end
      m_set = all_eq;
      if (phase == MAXV - 1) begin
        for (int i = 0; i < 3; i++) m_act[i] = m_work[i];
      end
      if ((m_cyc % FT) == FT - 1 && ena) begin
        for (int i = 0; i < 3; i++) begin
          if (m_work[i] < m_tgt[i]) m_work[i] = m_work[i] + 1;
          else if (m_work[i] > m_tgt[i]) m_work[i] = m_work[i] - 1;
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    check("model_pwm_out", int'(pwm_out), int'(m_out));
    check("model_settled", int'(settled), int'(m_set));
  end

  task automatic count_high(input int ch, input int n, output int h);
    h = 0;
    repeat (n) begin
      @(negedge clk);
      h += int'(pwm_out[ch]);
    end
  endtask

  task automatic do_reset(input logic [2:0] rgb, input logic [3:0] br);
    @(negedge clk);
    #2 rst = 1'b0;
    rgb_in     = rgb;
    brightness = br;
    ena        = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_settle(input int limit, output int edges);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!settled && edges < limit);
  endtask

  initial begin
    int         edges;
    int         h;
    int         mx;
    logic [7:0] wide;

    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_pwm_out", int'(pwm_out), 0);
      check("reset_settled", int'(settled), 1);
    end
    for (int i = 0; i < 3; i++) check("reset_work", int'(dut.work_q[i]), 0);

    // Fade in channel 0 to full scale: 15 steps every 4 clocks.
    rgb_in = 3'b001; brightness = 4'hF; rst = 1'b1;
    @(negedge clk);
    check("fadein_settled_drop", int'(settled), 0);
    edges = 1;
    while (!settled && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    check("fadein_settle_edges", edges, 61);
    check("model_work0_full", m_work[0], 15);
    repeat (30) @(negedge clk);
    count_high(0, 15, h);
    check("fadein_ch0_high", h, 15);

    // Channel 1 settled at duty 5, channel 0 ramps down meanwhile.
    rgb_in = 3'b010; brightness = 4'd5;
    wait_settle(300, edges);
    check("duty5_settled", int'(settled), 1);
    repeat (30) @(negedge clk);
    count_high(1, 15, h);
    check("duty5_ch1_high", h, 5);
    count_high(0, 15, h);
    check("duty5_ch0_off", h, 0);

    // Reversal at working duty 7.
    do_reset(3'b001, 4'hF);
    repeat (28) @(negedge clk);
    check("rev_start_duty", int'(dut.work_q[0]), 7);
    rgb_in = 3'b000;
    edges = 0;
    mx = 0;
    do begin
      @(negedge clk);
      edges++;
      if (int'(dut.work_q[0]) > mx) mx = int'(dut.work_q[0]);
      if (edges == 4) check("rev_first_step", int'(dut.work_q[0]), 6);
    end while (!settled && edges < 200);
    check("rev_settle_edges", edges, 29);
    check("rev_max", mx, 7);
    check("rev_final_duty", int'(dut.work_q[0]), 0);

    // Enable gating at duty 10.
    do_reset(3'b001, 4'd10);
    wait_settle(200, edges);
    check("ena_settle_edges", edges, 41);
    repeat (30) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check("ena_off_pwm", int'(pwm_out), 0);
    count_high(0, 19, h);
    check("ena_off_hold", h, 0);
    check("ena_off_duty", int'(dut.work_q[0]), 10);
    ena = 1'b1;
    repeat (30) @(negedge clk);
    count_high(0, 15, h);
    check("ena_resume_high", h, 10);

    // Truncated 255 gives all-ones brightness; then async reset mid-pulse.
    wide = 8'd255;
    do_reset(3'b111, wide[3:0]);
    wait_settle(200, edges);
    check("clamp_settle_edges", edges, 61);
    repeat (30) @(negedge clk);
    count_high(2, 15, h);
    check("clamp_ch2_high", h, 15);
    check("pre_reset_pwm", int'(pwm_out), 7);
    #2 rst = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm_out), 0);
    check("async_reset_settled", int'(settled), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
